safety_island_boot_ctrl: RTL and testbench

// - Boot sequencer between the safety-island bootmode strap and the CV32RT core.
// - Captures bootmode_i after reset and holds core fetch off while code is loaded.

---
 rtl/safety_island_boot_ctrl.sv | 146 ++++++++++++++
 tb/tb_safety_island_boot_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer for the safety-island CV32RT core: samples the bootmode strap after reset,
// holds fetch off until code is loaded, then releases fetch with a programmable boot address.
module safety_island_boot_ctrl #(
    parameter int unsigned          AddrWidth       = 32,
    parameter logic [AddrWidth-1:0] DefaultBootAddr = AddrWidth'(32'h0000_0080),
    parameter int unsigned          ResetDelay      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           bootmode_i,
    input  logic                 preload_done_i,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [3:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic                 reg_gnt_o,
    output logic                 reg_rvalid_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_err_o,
    output logic [AddrWidth-1:0] boot_addr_o,
    output logic                 fetch_enable_o,
    output logic                 boot_err_o
);

    localparam int unsigned CntW = $clog2(ResetDelay + 1);

    typedef enum logic [2:0] {
        RST_WAIT  = 3'd0,
        JTAG_WAIT = 3'd1,
        PRE_WAIT  = 3'd2,
        RUNNING   = 3'd3,
        ERROR     = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [AddrWidth-1:0] boot_addr_q, boot_addr_d;
    logic                 fetch_en_q;
    logic                 boot_err_q;

    logic                 rvalid_p1;
    logic [31:0]          rdata_p1;
    logic                 err_p1;

    logic                 start;
    logic                 locked;
    logic                 acc_err;
    logic [31:0]          rdata_d;
    logic [31:0]          status;
    logic                 unused_wdata;

    assign unused_wdata = ^reg_wdata_i[1:0];
    assign locked       = (state_q == RUNNING) || (state_q == ERROR);
    assign status       = {25'd0, boot_err_q, fetch_en_q, mode_q, state_q};

    // Register decode: one access per cycle, response lands in the _p1 stage.
    always_comb begin
        boot_addr_d = boot_addr_q;
        start       = 1'b0;
        acc_err     = 1'b0;
        rdata_d     = '0;
        if (reg_req_i) begin
            case (reg_addr_i)
                4'h0: begin
                    if (reg_we_i) begin
                        if (locked) acc_err = 1'b1;
                        else        boot_addr_d = {reg_wdata_i[AddrWidth-1:2], 2'b00};
                    end else begin
                        rdata_d = 32'(boot_addr_q);
                    end
                end
                4'h4: begin
                    if (reg_we_i) start = reg_wdata_i[0];
                end
                4'h8: begin
                    if (reg_we_i) acc_err = 1'b1;
                    else          rdata_d = status;
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            RST_WAIT: begin
                if (cnt_q != CntW'(ResetDelay)) cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(ResetDelay - 1)) begin
                    mode_d = bootmode_i;
                    case (bootmode_i)
                        2'b00:   state_d = JTAG_WAIT;
                        2'b01:   state_d = PRE_WAIT;
                        default: state_d = ERROR;
                    endcase
                end
            end
            JTAG_WAIT: if (start) state_d = RUNNING;
            PRE_WAIT:  if (start || preload_done_i) state_d = RUNNING;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST_WAIT;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            boot_addr_q <= DefaultBootAddr;
            fetch_en_q  <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            boot_addr_q <= boot_addr_d;
            fetch_en_q  <= (state_d == RUNNING);
            boot_err_q  <= (state_d == ERROR);
        end
    end

    // Response stage: valid follows every granted request by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_p1 <= 1'b0;
            rdata_p1  <= '0;
            err_p1    <= 1'b0;
        end else begin
            rvalid_p1 <= reg_req_i;
            rdata_p1  <= rdata_d;
            err_p1    <= acc_err;
        end
    end

    assign reg_gnt_o      = reg_req_i;
    assign reg_rvalid_o   = rvalid_p1;
    assign reg_rdata_o    = rdata_p1;
    assign reg_err_o      = err_p1;
    assign boot_addr_o    = boot_addr_q;
    assign fetch_enable_o = fetch_en_q;
    assign boot_err_o     = boot_err_q;

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Scoreboard bench for safety_island_boot_ctrl: register responses are queued at issue
// and checked by a separate monitor; boot outputs are checked directly.
module tb_safety_island_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  bootmode;
    logic        preload_done;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] boot_addr;
    logic        fetch_en;
    logic        boot_err;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    safety_island_boot_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bootmode_i     (bootmode),
        .preload_done_i (preload_done),
        .reg_req_i      (req),
        .reg_we_i       (we),
        .reg_addr_i     (addr),
        .reg_wdata_i    (wdata),
        .reg_gnt_o      (gnt),
        .reg_rvalid_o   (rvalid),
        .reg_rdata_o    (rdata),
        .reg_err_o      (err),
        .boot_addr_o    (boot_addr),
        .fetch_enable_o (fetch_en),
        .boot_err_o     (boot_err)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expected response per rvalid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rvalid: got rvalid=1, expected no response");
            end else begin
                logic [32:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check32({nm, "_err"}, {31'd0, err}, {31'd0, e[32]});
                check32({nm, "_rdata"}, rdata, e[31:0]);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_access(input bit w, input logic [3:0] a, input logic [31:0] wd,
                              input bit exp_err, input logic [31:0] exp_rd, input string nm);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = wd;
        #1;
        check32({nm, "_gnt"}, {31'd0, gnt}, 32'd1);
        exp_q.push_back({exp_err, exp_rd});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = '0;
    endtask

    task automatic apply_reset(input logic [1:0] mode);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        bootmode = mode;
        #1;
        check32("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
        check32("rst_boot_err", {31'd0, boot_err}, 32'd0);
        check32("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check32("rst_reg_err", {31'd0, err}, 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_boot_addr", boot_addr, 32'h80);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_preload();
        preload_done = 1'b1;
        @(posedge clk);
        #1;
        preload_done = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        bootmode     = 2'b00;
        preload_done = 1'b0;
        req          = 1'b0;
        we           = 1'b0;
        addr         = 4'h0;
        wdata        = '0;

        // Jtag mode: idle, then load address and start.
        apply_reset(2'b00);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h00, "status_rstwait");
        wait_cycles(100);
        check32("jtag_idle_fetch", {31'd0, fetch_en}, 32'd0);
        check32("jtag_idle_addr", boot_addr, 32'h80);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h01, "status_jtag_wait");
        reg_access(1'b1, 4'h0, 32'h1003, 1'b0, 32'h0, "wr_boot_addr");
        check32("jtag_addr_aligned", boot_addr, 32'h1000);
        check32("jtag_prestart_fetch", {31'd0, fetch_en}, 32'd0);
        reg_access(1'b1, 4'h4, 32'h1, 1'b0, 32'h0, "wr_ctrl_start");
        check32("jtag_fetch_en", {31'd0, fetch_en}, 32'd1);
        reg_access(1'b0, 4'h0, 32'h0, 1'b0, 32'h1000, "rd_boot_addr");
        reg_access(1'b0, 4'h4, 32'h0, 1'b0, 32'h0, "rd_ctrl");
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h23, "status_running");
        reg_access(1'b1, 4'h0, 32'h4000, 1'b1, 32'h0, "wr_boot_addr_locked");
        reg_access(1'b1, 4'h8, 32'hFF, 1'b1, 32'h0, "wr_status");
        reg_access(1'b0, 4'hC, 32'h0, 1'b1, 32'h0, "rd_unmapped");
        check32("jtag_addr_locked", boot_addr, 32'h1000);

        // Async reset while RUNNING (checked inside apply_reset), Preloaded mode.
        apply_reset(2'b01);
        wait_cycles(20);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h0A, "status_pre_wait");
        pulse_preload();
        check32("pre_fetch_en", {31'd0, fetch_en}, 32'd1);
        reg_access(1'b1, 4'h0, 32'h2000, 1'b1, 32'h0, "pre_wr_locked");
        check32("pre_addr_unchanged", boot_addr, 32'h80);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h2B, "status_pre_run");

        // BOOT_ADDR write in the same cycle as the preload-driven transition still lands.
        apply_reset(2'b01);
        wait_cycles(20);
        preload_done = 1'b1;
        reg_access(1'b1, 4'h0, 32'h3000, 1'b0, 32'h0, "wr_addr_at_transition");
        preload_done = 1'b0;
        check32("edge_addr", boot_addr, 32'h3000);
        check32("edge_fetch_en", {31'd0, fetch_en}, 32'd1);

        // Illegal strap.
        apply_reset(2'b11);
        wait_cycles(20);
        check32("illegal_boot_err", {31'd0, boot_err}, 32'd1);
        reg_access(1'b1, 4'h4, 32'h1, 1'b0, 32'h0, "illegal_ctrl_start");
        check32("illegal_fetch_en", {31'd0, fetch_en}, 32'd0);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h5C, "status_error");
        reg_access(1'b1, 4'h0, 32'h5000, 1'b1, 32'h0, "illegal_wr_locked");

        // Strap changes after the sample point are ignored.
        apply_reset(2'b00);
        wait_cycles(18);
        bootmode = 2'b01;
        wait_cycles(3);
        pulse_preload();
        wait_cycles(2);
        check32("toggle_fetch_en", {31'd0, fetch_en}, 32'd0);
        reg_access(1'b0, 4'h8, 32'h0, 1'b0, 32'h01, "status_toggle");

        wait_cycles(3);
        check32("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
